// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and a
// ceiling-log2 helper usable in parameter expressions.
package fifo_arb_defs;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Ceiling log2 for tools without $clog2; clog2(1) = 0, clog2(4) = 2, clog2(17) = 5.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or above
// the pointer, wrapping modulo NREQ, using a double-width masked priority encode.
module rr_pick
    import fifo_arb_defs::*;
#(
    parameter int NREQ = 4,
    parameter int GW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   ptr,
    output logic [GW-1:0]   winner,
    output logic            any_valid
);

    logic [2*NREQ-1:0] masked;

    assign any_valid = |req;

    // Lower copy keeps only requests at or above the pointer; upper copy supplies the wrap-around.
    always_comb begin
        masked = {req, req};
        for (int i = 0; i < NREQ; i++) begin
            if (i < int'(ptr)) begin
                masked[i] = 1'b0;
            end
        end
    end

    // Lowest set bit of the doubled vector wins; fold its index back into 0..NREQ-1.
    always_comb begin
        // NOTE: default first so every path assigns winner and no latch is inferred.
        winner = '0;
        for (int i = 2*NREQ-1; i >= 0; i--) begin
            if (masked[i]) begin
                winner = GW'((i >= NREQ) ? (i - NREQ) : i);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter sharing one FIFO write port among NREQ
// requesters. A granted requester keeps the port until its last beat, or until
// MAXPKT beats have gone through, in which case the packet is cut and pkt_err set.
module fifo_wr_arbiter
    import fifo_arb_defs::*;
#(
    parameter int  NREQ   = 4,
    parameter int  DSIZE  = 8,
    parameter int  MAXPKT = 16,
    localparam int GW     = clog2(NREQ)
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [GW-1:0]         grant_id,
    output logic                  busy,
    output logic                  pkt_err,
    input  logic                  err_clr
);

    localparam int            CW       = clog2(MAXPKT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAXPKT - 1);

    state_t        state;
    logic [GW-1:0] ptr;
    logic [CW-1:0] beat_cnt;
    logic [GW-1:0] pick_id;
    logic          pick_any;
    logic          sel_valid;
    logic          sel_last;
    logic          accept;
    logic          hit_max;
    logic [GW-1:0] next_ptr;

    rr_pick #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_pick (
        .req       (req_valid),
        .ptr       (ptr),
        .winner    (pick_id),
        .any_valid (pick_any)
    );

    assign busy      = (state == XFER);
    assign sel_valid = req_valid[grant_id];
    assign sel_last  = req_last[grant_id];
    assign winc      = busy & sel_valid & ~wfull;
    assign accept    = winc;
    // beat_cnt counts beats already accepted, so LAST_CNT means this beat is number MAXPKT.
    assign hit_max   = (beat_cnt == LAST_CNT);
    assign next_ptr  = (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

    // Only the granted requester sees ready, and only while the FIFO has room.
    always_comb begin
        req_ready = '0;
        if (busy && !wfull) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Data mux from the granted requester; held at zero outside a packet.
    always_comb begin
        wdata = '0;
        if (busy) begin
            wdata = req_data[int'(grant_id)*DSIZE +: DSIZE];
        end
    end

    // FSM with grant, round-robin pointer, beat counter and sticky error flag.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
            pkt_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop here samples pre-edge values.
            if (accept && !sel_last && hit_max) begin
                pkt_err <= 1'b1;
            end else if (err_clr) begin
                pkt_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_id;
                        beat_cnt <= '0;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (accept) begin
                        if (sel_last || hit_max) begin
                            state    <= IDLE;
                            ptr      <= next_ptr;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-requester beat queues drive the handshakes,
// expected FIFO writes (grant + data) go into a scoreboard queue when a test
// issues them, and a monitor pops and compares on every winc.
module tb_fifo_wr_arbiter;

    localparam int NREQ   = 4;
    localparam int DSIZE  = 8;
    localparam int MAXPKT = 16;
    localparam int GW     = 2;

    typedef struct packed {
        logic [DSIZE-1:0] data;
        logic             last;
    } beat_t;

    typedef struct packed {
        logic [GW-1:0]    gid;
        logic [DSIZE-1:0] data;
    } exp_t;

    logic                  wclk;
    logic                  wrst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [GW-1:0]         grant_id;
    logic                  busy;
    logic                  pkt_err;
    logic                  err_clr;

    beat_t           src_q[NREQ][$];
    exp_t            exp_q[$];
    logic [NREQ-1:0] fire;
    int              n_cmp;
    int              n_fail;
    int              cyc;
    int              first_w;
    int              last_w;

    fifo_wr_arbiter #(
        .NREQ   (NREQ),
        .DSIZE  (DSIZE),
        .MAXPKT (MAXPKT)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy),
        .pkt_err   (pkt_err),
        .err_clr   (err_clr)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_src(input int id, input int n, input logic [DSIZE-1:0] base);
        for (int b = 0; b < n; b++) begin
            src_q[id].push_back('{data: base + DSIZE'(b), last: (b == n - 1)});
        end
    endtask

    task automatic push_exp(input int id, input int n, input logic [DSIZE-1:0] base);
        for (int b = 0; b < n; b++) begin
            exp_q.push_back('{gid: GW'(id), data: base + DSIZE'(b)});
        end
    endtask

    task automatic push_pkt(input int id, input int n, input logic [DSIZE-1:0] base);
        push_src(id, n, base);
        push_exp(id, n, base);
    endtask

    function automatic bit all_sent();
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Wait (bounded) until every issued beat is sent, written and the arbiter is idle.
    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0 || !all_sent()) && n < budget) begin
            @(negedge wclk);
            #1;
            n++;
        end
        check(name, 32'(n < budget), 32'd1);
    endtask

    // Requester driver: retire beats accepted at the last edge, present the next one.
    initial begin : driver
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge wclk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (fire[i] && src_q[i].size() != 0) begin
                    void'(src_q[i].pop_front());
                end
                if (src_q[i].size() != 0) begin
                    req_valid[i]                = 1'b1;
                    req_data[i*DSIZE +: DSIZE]  = src_q[i][0].data;
                    req_last[i]                 = src_q[i][0].last;
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    // Monitor: record handshakes and check every FIFO write against the scoreboard.
    initial begin : monitor
        exp_t e;
        fire    = '0;
        cyc     = 0;
        first_w = -1;
        last_w  = -1;
        forever begin
            @(negedge wclk);
            cyc++;
            fire = req_valid & req_ready;
            if (winc === 1'b1) begin
                if (first_w < 0) first_w = cyc;
                last_w = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(wdata), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("write_grant", 32'(grant_id), 32'(e.gid));
                    check("write_data", 32'(wdata), 32'(e.data));
                end
            end
        end
    end

    initial begin : guard
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish before 1ms");
        $fatal(1, "simulation timeout");
    end

    initial begin : stimulus
        n_cmp   = 0;
        n_fail  = 0;
        wrst_n  = 1'b0;
        wfull   = 1'b0;
        err_clr = 1'b0;

        // Reset state
        repeat (3) @(negedge wclk);
        check("rst_winc", 32'(winc), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_grant", 32'(grant_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pkt_err", 32'(pkt_err), 0);
        check("rst_wdata", 32'(wdata), 0);
        @(posedge wclk);
        #2 wrst_n = 1'b1;
        @(negedge wclk);
        #1;

        // Single packet: requester 2, three beats
        push_pkt(2, 3, 8'h21);
        @(negedge wclk);
        check("t1_idle_busy", 32'(busy), 0);
        check("t1_idle_ready", 32'(req_ready), 0);
        @(negedge wclk);
        check("t1_grant", 32'(grant_id), 2);
        check("t1_busy", 32'(busy), 1);
        check("t1_winc_b1", 32'(winc), 1);
        @(negedge wclk);
        check("t1_winc_b2", 32'(winc), 1);
        @(negedge wclk);
        check("t1_winc_b3", 32'(winc), 1);
        @(negedge wclk);
        check("t1_winc_done", 32'(winc), 0);
        check("t1_busy_done", 32'(busy), 0);
        drain("t1_drain", 20);

        // Pointer is now 3: requester 3 beats requester 0
        push_pkt(3, 1, 8'h31);
        push_pkt(0, 1, 8'h01);
        drain("t2_drain", 20);

        // Reset during beat 2 of 5 from requester 0; only beat 1 reaches the FIFO
        push_src(0, 5, 8'h0A);
        push_exp(0, 1, 8'h0A);
        repeat (3) @(posedge wclk);
        #2 wrst_n = 1'b0;
        #1;
        check("t3_rst_winc", 32'(winc), 0);
        check("t3_rst_ready", 32'(req_ready), 0);
        check("t3_rst_busy", 32'(busy), 0);
        check("t3_rst_grant", 32'(grant_id), 0);
        check("t3_rst_wdata", 32'(wdata), 0);
        src_q[0].delete();
        @(posedge wclk);
        #2 wrst_n = 1'b1;
        @(negedge wclk);
        check("t3_post_grant", 32'(grant_id), 0);
        check("t3_post_busy", 32'(busy), 0);
        check("t3_post_beats", 32'(exp_q.size()), 0);

        // Fairness: everyone sends two 2-beat packets; order 0,1,2,3,0,1,2,3
        first_w = -1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                push_pkt(i, 2, 8'h40 + 8'(i*8 + k*2));
            end
        end
        drain("t4_drain", 80);
        check("t4_span", 32'(last_w - first_w), 22);

        // Watchdog: requester 1 sends 20 beats, last flag only on beat 20
        push_pkt(1, 20, 8'h80);
        repeat (17) @(posedge wclk);
        #1 err_clr = 1'b1;
        @(negedge wclk);
        check("t5_err_before", 32'(pkt_err), 0);
        check("t5_busy_before", 32'(busy), 1);
        @(posedge wclk);
        #1 err_clr = 1'b0;
        @(negedge wclk);
        check("t5_err_set_wins", 32'(pkt_err), 1);
        check("t5_cut_idle", 32'(busy), 0);
        @(negedge wclk);
        check("t5_regrant_busy", 32'(busy), 1);
        check("t5_regrant_id", 32'(grant_id), 1);
        drain("t5_drain", 40);
        check("t5_err_sticky", 32'(pkt_err), 1);
        @(posedge wclk);
        #1 err_clr = 1'b1;
        @(posedge wclk);
        #1 err_clr = 1'b0;
        @(negedge wclk);
        check("t5_err_cleared", 32'(pkt_err), 0);

        // Backpressure: wfull for 4 cycles after beat 2 of requester 2
        push_pkt(2, 6, 8'hC0);
        repeat (4) @(posedge wclk);
        #1 wfull = 1'b1;
        repeat (4) begin
            @(negedge wclk);
            check("t6_full_winc", 32'(winc), 0);
            check("t6_full_ready", 32'(req_ready), 0);
            check("t6_full_grant", 32'(grant_id), 2);
            check("t6_full_busy", 32'(busy), 1);
        end
        @(posedge wclk);
        #1 wfull = 1'b0;
        drain("t6_drain", 40);

        // Atomicity: requester 3 waits for requester 0's whole packet
        push_src(0, 5, 8'hE0);
        push_exp(0, 5, 8'hE0);
        push_exp(3, 2, 8'hF0);
        repeat (3) @(posedge wclk);
        #2 push_src(3, 2, 8'hF0);
        repeat (4) begin
            @(negedge wclk);
            check("t7_ready3_blocked", 32'(req_ready[3]), 0);
            check("t7_grant_held", 32'(grant_id), 0);
        end
        @(negedge wclk);
        check("t7_idle_after_last", 32'(busy), 0);
        check("t7_ready3_idle", 32'(req_ready[3]), 0);
        @(negedge wclk);
        check("t7_grant3", 32'(grant_id), 3);
        check("t7_busy3", 32'(busy), 1);
        drain("t7_drain", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
